// File: rtl/rc4_stream_feeder.sv
// Upstream sequencer for the rc4 core: key store, plaintext FIFO and the start/key/plaintext
// handshake sequencing, with HOLD on plaintext underrun.
module rc4_stream_feeder #(
    parameter int unsigned KEY_MAX  = 32,
    parameter int unsigned PT_DEPTH = 16,
    parameter int unsigned PT_AW    = 4
) (
    input  logic        CLK_IN,
    input  logic        RESET_N_IN,
    input  logic        KEY_WE_IN,
    input  logic [4:0]  KEY_ADDR_IN,
    input  logic [7:0]  KEY_DATA_IN,
    input  logic [5:0]  KEY_LEN_IN,
    input  logic [15:0] PT_LEN_IN,
    input  logic        GO_IN,
    input  logic        ABORT_IN,
    input  logic        PT_VALID_IN,
    input  logic [7:0]  PT_DATA_IN,
    output logic        PT_READY_OUT,
    output logic        BUSY_OUT,
    output logic        DONE_OUT,
    output logic        RC4_START_OUT,
    output logic        RC4_STOP_OUT,
    output logic        RC4_HOLD_OUT,
    output logic [7:0]  RC4_KEY_SIZE_OUT,
    output logic [7:0]  RC4_KEY_BYTE_OUT,
    output logic [7:0]  RC4_PLAIN_BYTE_OUT,
    input  logic        RC4_START_KEY_CPY_IN,
    input  logic        RC4_READ_PLAINTEXT_IN
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitKcpy,
        StKey,
        StWaitPt,
        StPt,
        StDone
    } state_e;

    localparam logic [5:0]     KeyMaxLen = 6'(KEY_MAX);
    localparam logic [PT_AW:0] FullCount = (PT_AW + 1)'(PT_DEPTH);
    localparam logic [PT_AW:0] CountOne  = (PT_AW + 1)'(1);
    localparam logic [PT_AW-1:0] PtrOne  = PT_AW'(1);

    logic [7:0] key_mem [KEY_MAX];
    logic [7:0] pt_mem [PT_DEPTH];

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  key_size_q, key_size_d;
    logic [7:0]  key_byte_q, key_byte_d;
    logic [7:0]  plain_q, plain_d;
    logic        hold_q, hold_d;
    logic        stop_q, stop_d;

    logic [PT_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PT_AW:0]   count_q;

    logic       push, pop, flush, pt_step, abort;
    logic [5:0] key_len_eff;

    assign key_len_eff = (KEY_LEN_IN == 6'd0 || KEY_LEN_IN > KeyMaxLen) ? KeyMaxLen : KEY_LEN_IN;
    assign abort       = ABORT_IN && (state_q != StIdle);
    // Full/empty come from the registered count, so a fresh push is never popped on the same edge.
    assign push        = PT_VALID_IN && (count_q != FullCount) && !flush;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        key_size_d = key_size_q;
        key_byte_d = key_byte_q;
        plain_d    = plain_q;
        hold_d     = hold_q;
        stop_d     = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        pt_step    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (GO_IN && PT_LEN_IN != 16'd0) begin
                    key_size_d = {2'b00, key_len_eff};
                    rem_d      = PT_LEN_IN;
                    state_d    = StStart;
                end
            end
            StStart: state_d = StWaitKcpy;
            StWaitKcpy: begin
                if (RC4_START_KEY_CPY_IN) begin
                    key_byte_d = key_mem[0];
                    idx_d      = 6'd1;
                    state_d    = StKey;
                end
            end
            StKey: begin
                if (idx_q < key_size_q[5:0]) begin
                    key_byte_d = key_mem[idx_q[4:0]];
                    idx_d      = idx_q + 6'd1;
                end else begin
                    key_byte_d = 8'h00;
                    state_d    = StWaitPt;
                end
            end
            StWaitPt: begin
                if (RC4_READ_PLAINTEXT_IN) begin
                    pt_step = 1'b1;
                    state_d = StPt;
                end
            end
            StPt: begin
                if (rem_q == 16'd0) begin
                    plain_d = 8'h00;
                    hold_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    pt_step = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (pt_step) begin
            if (count_q != '0) begin
                pop     = 1'b1;
                plain_d = pt_mem[rd_ptr_q];
                hold_d  = 1'b0;
                rem_d   = rem_q - 16'd1;
            end else begin
                hold_d = 1'b1;
            end
        end

        if (abort) begin
            state_d    = StIdle;
            stop_d     = 1'b1;
            flush      = 1'b1;
            pop        = 1'b0;
            hold_d     = 1'b0;
            key_byte_d = 8'h00;
            plain_d    = 8'h00;
            idx_d      = 6'd0;
            rem_d      = 16'd0;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q    <= StIdle;
            idx_q      <= 6'd0;
            rem_q      <= 16'd0;
            key_size_q <= 8'h00;
            key_byte_q <= 8'h00;
            plain_q    <= 8'h00;
            hold_q     <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            key_size_q <= key_size_d;
            key_byte_q <= key_byte_d;
            plain_q    <= plain_d;
            hold_q     <= hold_d;
            stop_q     <= stop_d;
        end
    end

    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CountOne;
                2'b01:   count_q <= count_q - CountOne;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage arrays carry no reset; the key survives reset by design.
    always_ff @(posedge CLK_IN) begin
        if (push) pt_mem[wr_ptr_q] <= PT_DATA_IN;
        if (KEY_WE_IN && state_q == StIdle) key_mem[KEY_ADDR_IN] <= KEY_DATA_IN;
    end

    assign PT_READY_OUT       = (count_q != FullCount);
    assign BUSY_OUT           = (state_q != StIdle);
    assign DONE_OUT           = (state_q == StDone);
    assign RC4_START_OUT      = (state_q == StStart);
    assign RC4_STOP_OUT       = stop_q;
    assign RC4_HOLD_OUT       = hold_q;
    assign RC4_KEY_SIZE_OUT   = key_size_q;
    assign RC4_KEY_BYTE_OUT   = key_byte_q;
    assign RC4_PLAIN_BYTE_OUT = plain_q;

endmodule

// File: tb/tb_rc4_stream_feeder.sv
// Self-checking bench for rc4_stream_feeder: randomized messages against a queue-based model
// of the key store and plaintext FIFO, plus directed underrun, full, abort and reset cases.
module tb_rc4_stream_feeder;

    logic        CLK_IN = 1'b0;
    logic        RESET_N_IN;
    logic        KEY_WE_IN;
    logic [4:0]  KEY_ADDR_IN;
    logic [7:0]  KEY_DATA_IN;
    logic [5:0]  KEY_LEN_IN;
    logic [15:0] PT_LEN_IN;
    logic        GO_IN;
    logic        ABORT_IN;
    logic        PT_VALID_IN;
    logic [7:0]  PT_DATA_IN;
    logic        PT_READY_OUT;
    logic        BUSY_OUT;
    logic        DONE_OUT;
    logic        RC4_START_OUT;
    logic        RC4_STOP_OUT;
    logic        RC4_HOLD_OUT;
    logic [7:0]  RC4_KEY_SIZE_OUT;
    logic [7:0]  RC4_KEY_BYTE_OUT;
    logic [7:0]  RC4_PLAIN_BYTE_OUT;
    logic        RC4_START_KEY_CPY_IN;
    logic        RC4_READ_PLAINTEXT_IN;

    rc4_stream_feeder dut (
        .CLK_IN                (CLK_IN),
        .RESET_N_IN            (RESET_N_IN),
        .KEY_WE_IN             (KEY_WE_IN),
        .KEY_ADDR_IN           (KEY_ADDR_IN),
        .KEY_DATA_IN           (KEY_DATA_IN),
        .KEY_LEN_IN            (KEY_LEN_IN),
        .PT_LEN_IN             (PT_LEN_IN),
        .GO_IN                 (GO_IN),
        .ABORT_IN              (ABORT_IN),
        .PT_VALID_IN           (PT_VALID_IN),
        .PT_DATA_IN            (PT_DATA_IN),
        .PT_READY_OUT          (PT_READY_OUT),
        .BUSY_OUT              (BUSY_OUT),
        .DONE_OUT              (DONE_OUT),
        .RC4_START_OUT         (RC4_START_OUT),
        .RC4_STOP_OUT          (RC4_STOP_OUT),
        .RC4_HOLD_OUT          (RC4_HOLD_OUT),
        .RC4_KEY_SIZE_OUT      (RC4_KEY_SIZE_OUT),
        .RC4_KEY_BYTE_OUT      (RC4_KEY_BYTE_OUT),
        .RC4_PLAIN_BYTE_OUT    (RC4_PLAIN_BYTE_OUT),
        .RC4_START_KEY_CPY_IN  (RC4_START_KEY_CPY_IN),
        .RC4_READ_PLAINTEXT_IN (RC4_READ_PLAINTEXT_IN)
    );

    always #5 CLK_IN = ~CLK_IN;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] key_ref [32];
    logic [7:0] pt_model [$];
    logic [7:0] late_q [$];
    logic [7:0] exp_plain;
    int         push_mode;
    int         late_at;
    int         pt_cyc;
    int         hold_cnt;
    int         done_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {2'b00, PT_READY_OUT, BUSY_OUT, DONE_OUT, RC4_START_OUT, RC4_STOP_OUT,
                RC4_HOLD_OUT, RC4_KEY_SIZE_OUT, RC4_KEY_BYTE_OUT, RC4_PLAIN_BYTE_OUT};
    endfunction

    // One clock: drive pushes, advance the FIFO model (pop sees pre-push contents), cross one edge.
    task automatic tick(input bit step, output bit popped, output logic [7:0] pb);
        bit acc;
        popped = 1'b0;
        pb     = 8'h00;
        if (push_mode == 1) begin
            PT_VALID_IN = ($urandom_range(0, 2) != 0);
            PT_DATA_IN  = 8'($urandom);
        end else if (push_mode == 2) begin
            PT_VALID_IN = (pt_cyc >= late_at) && (late_q.size() > 0);
            PT_DATA_IN  = (late_q.size() > 0) ? late_q[0] : 8'h00;
        end else begin
            PT_VALID_IN = 1'b0;
        end
        check_eq("pt_ready", 32'(PT_READY_OUT), 32'(pt_model.size() < 16));
        acc = PT_VALID_IN && (pt_model.size() < 16);
        if (step && pt_model.size() > 0) begin
            pb     = pt_model.pop_front();
            popped = 1'b1;
        end
        if (acc) begin
            pt_model.push_back(PT_DATA_IN);
            if (push_mode == 2) void'(late_q.pop_front());
        end
        @(negedge CLK_IN);
        PT_VALID_IN = 1'b0;
    endtask

    task automatic write_key(input logic [4:0] addr, input logic [7:0] data);
        bit p;
        logic [7:0] b;
        KEY_WE_IN   = 1'b1;
        KEY_ADDR_IN = addr;
        KEY_DATA_IN = data;
        tick(1'b0, p, b);
        KEY_WE_IN = 1'b0;
        key_ref[addr] = data;
    endtask

    task automatic run_msg(input int klen, input int ptlen, input int kdelay, input int rdelay,
                           input int abort_idx);
        bit p;
        logic [7:0] b;
        int kl, left, guard;
        kl       = (klen == 0 || klen > 32) ? 32 : klen;
        pt_cyc   = -1000000;
        hold_cnt = 0;
        KEY_LEN_IN = 6'(klen);
        PT_LEN_IN  = 16'(ptlen);
        GO_IN      = 1'b1;
        tick(1'b0, p, b);
        GO_IN = 1'b0;
        check_eq("start_pulse", 32'(RC4_START_OUT), 32'd1);
        check_eq("busy_start", 32'(BUSY_OUT), 32'd1);
        check_eq("key_size", 32'(RC4_KEY_SIZE_OUT), 32'(kl));
        tick(1'b0, p, b);
        check_eq("start_one_cycle", 32'(RC4_START_OUT), 32'd0);
        for (int d = 0; d < kdelay; d++) begin
            // Writes while busy must not reach the key store; the model is left untouched.
            KEY_WE_IN   = 1'b1;
            KEY_ADDR_IN = 5'($urandom);
            KEY_DATA_IN = 8'($urandom);
            tick(1'b0, p, b);
            KEY_WE_IN = 1'b0;
            check_eq("kcpy_wait_byte", 32'(RC4_KEY_BYTE_OUT), 32'd0);
        end
        RC4_START_KEY_CPY_IN = 1'b1;
        tick(1'b0, p, b);
        RC4_START_KEY_CPY_IN = 1'b0;
        for (int i = 0; i < kl; i++) begin
            check_eq($sformatf("key_byte[%0d]", i), 32'(RC4_KEY_BYTE_OUT), 32'(key_ref[i]));
            if (i + 1 == abort_idx) begin
                ABORT_IN = 1'b1;
                tick(1'b0, p, b);
                ABORT_IN = 1'b0;
                pt_model.delete();
                exp_plain = 8'h00;
                check_eq("abort_stop", 32'(RC4_STOP_OUT), 32'd1);
                check_eq("abort_busy", 32'(BUSY_OUT), 32'd0);
                check_eq("abort_bytes", {16'h0, RC4_KEY_BYTE_OUT, RC4_PLAIN_BYTE_OUT}, 32'd0);
                check_eq("abort_done", 32'(DONE_OUT), 32'd0);
                tick(1'b0, p, b);
                check_eq("abort_stop_one", 32'(RC4_STOP_OUT), 32'd0);
                check_eq("abort_no_done", 32'(DONE_OUT), 32'd0);
                return;
            end
            tick(1'b0, p, b);
        end
        check_eq("key_tail_zero", 32'(RC4_KEY_BYTE_OUT), 32'd0);
        for (int d = 0; d < rdelay; d++) begin
            tick(1'b0, p, b);
            check_eq("wait_pt_hold", 32'(RC4_HOLD_OUT), 32'd0);
            check_eq("wait_pt_plain", 32'(RC4_PLAIN_BYTE_OUT), 32'(exp_plain));
        end
        RC4_READ_PLAINTEXT_IN = 1'b1;
        left   = ptlen;
        guard  = 0;
        pt_cyc = 0;
        tick(1'b1, p, b);
        RC4_READ_PLAINTEXT_IN = 1'b0;
        while (1) begin
            if (p) begin
                left--;
                exp_plain = b;
            end else begin
                hold_cnt++;
            end
            check_eq("pt_hold", 32'(RC4_HOLD_OUT), 32'(!p));
            check_eq("pt_byte", 32'(RC4_PLAIN_BYTE_OUT), 32'(exp_plain));
            if (left == 0) break;
            guard++;
            if (guard > 500) begin
                check_eq("pt_timeout_left", 32'(left), 32'd0);
                return;
            end
            pt_cyc++;
            tick(1'b1, p, b);
        end
        tick(1'b0, p, b);
        exp_plain = 8'h00;
        check_eq("done_pulse", 32'(DONE_OUT), 32'd1);
        check_eq("done_outs", {RC4_HOLD_OUT, RC4_PLAIN_BYTE_OUT}, 32'd0);
        done_cnt++;
        tick(1'b0, p, b);
        check_eq("done_one_cycle", 32'(DONE_OUT), 32'd0);
        check_eq("idle_after_done", 32'(BUSY_OUT), 32'd0);
    endtask

    logic [255:0] kv;
    logic [255:0] pv;
    bit           tp;
    logic [7:0]   tb_b;

    initial begin
        kv = 256'hae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405;
        pv = 256'h3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595;
        KEY_WE_IN = 0; KEY_ADDR_IN = 0; KEY_DATA_IN = 0; KEY_LEN_IN = 0; PT_LEN_IN = 0;
        GO_IN = 0; ABORT_IN = 0; PT_VALID_IN = 0; PT_DATA_IN = 0;
        RC4_START_KEY_CPY_IN = 0; RC4_READ_PLAINTEXT_IN = 0;
        push_mode = 0; late_at = 0; pt_cyc = 0; exp_plain = 8'h00; done_cnt = 0;
        RESET_N_IN = 1'b0;
        #1;
        check_eq("reset_outs", all_outs(), 32'h2000_0000);
        @(negedge CLK_IN);
        @(negedge CLK_IN);
        RESET_N_IN = 1'b1;
        @(negedge CLK_IN);

        // Key stream with the reference key.
        for (int i = 0; i < 32; i++) write_key(5'(i), kv[255 - 8 * i -: 8]);
        push_mode = 1;
        run_msg(32, 6, 2, 1, -1);

        // Idle-only effects: GO with zero length and ABORT are both ignored.
        PT_LEN_IN = 16'd0;
        GO_IN     = 1'b1;
        ABORT_IN  = 1'b1;
        tick(1'b0, tp, tb_b);
        GO_IN    = 1'b0;
        ABORT_IN = 1'b0;
        check_eq("go_len0_busy", 32'(BUSY_OUT), 32'd0);
        check_eq("abort_idle_stop", 32'(RC4_STOP_OUT), 32'd0);

        // Drain whatever random preload is left so the directed cases start empty.
        push_mode = 0;
        if (pt_model.size() > 0) run_msg(4, pt_model.size(), 0, 0, -1);

        // Underrun: two preloaded bytes, two more arrive five edges after READ.
        push_mode = 2;
        pt_cyc    = 0;
        late_at   = 0;
        late_q    = '{8'h3a, 8'he2};
        tick(1'b0, tp, tb_b);
        tick(1'b0, tp, tb_b);
        late_q  = '{8'h80, 8'hd0};
        late_at = 5;
        run_msg(5, 4, 1, 0, -1);
        check_eq("underrun_holds", 32'(hold_cnt), 32'd4);

        // FIFO full: 17 offered in idle, the 17th is refused.
        pt_cyc  = 0;
        late_at = 0;
        late_q.delete();
        for (int i = 0; i < 17; i++) late_q.push_back(8'($urandom));
        for (int i = 0; i < 17; i++) tick(1'b0, tp, tb_b);
        check_eq("full_ready", 32'(PT_READY_OUT), 32'd0);
        check_eq("full_depth", 32'(pt_model.size()), 32'd16);
        late_q.delete();
        push_mode = 0;
        run_msg(2, 16, 0, 0, -1);

        // Abort during key copy at idx=10, then the key store must accept writes again.
        push_mode = 1;
        run_msg(32, 5, 1, 0, 10);
        push_mode = 0;
        write_key(5'd0, 8'h5a);
        write_key(5'd1, 8'hc3);
        push_mode = 1;
        run_msg(3, 3, 0, 1, -1);

        // End-to-end vector: 16 preloaded, the rest streamed in behind.
        push_mode = 0;
        if (pt_model.size() > 0) run_msg(1, pt_model.size(), 0, 0, -1);
        for (int i = 0; i < 32; i++) write_key(5'(i), kv[255 - 8 * i -: 8]);
        push_mode = 2;
        pt_cyc    = 0;
        late_at   = 0;
        late_q.delete();
        for (int i = 0; i < 16; i++) late_q.push_back(pv[255 - 8 * i -: 8]);
        for (int i = 0; i < 16; i++) tick(1'b0, tp, tb_b);
        for (int i = 16; i < 32; i++) late_q.push_back(pv[255 - 8 * i -: 8]);
        run_msg(32, 32, 3, 2, -1);
        check_eq("e2e_all_pushed", 32'(late_q.size()), 32'd0);

        // Randomized messages with random key edits, lengths, delays and occasional abort.
        push_mode = 1;
        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < 4; w++) write_key(5'($urandom), 8'($urandom));
            run_msg($urandom_range(0, 63), $urandom_range(1, 40), $urandom_range(0, 4),
                    $urandom_range(0, 4), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1);
        end

        // Asynchronous reset in the middle of a key copy.
        KEY_LEN_IN = 6'd8;
        PT_LEN_IN  = 16'd4;
        GO_IN      = 1'b1;
        tick(1'b0, tp, tb_b);
        GO_IN = 1'b0;
        tick(1'b0, tp, tb_b);
        RC4_START_KEY_CPY_IN = 1'b1;
        tick(1'b0, tp, tb_b);
        RC4_START_KEY_CPY_IN = 1'b0;
        tick(1'b0, tp, tb_b);
        check_eq("pre_reset_busy", 32'(BUSY_OUT), 32'd1);
        #2;
        RESET_N_IN = 1'b0;
        #1;
        check_eq("async_reset_outs", all_outs(), 32'h2000_0000);
        @(negedge CLK_IN);
        RESET_N_IN = 1'b1;
        pt_model.delete();
        exp_plain = 8'h00;
        @(negedge CLK_IN);
        // Key store survives reset.
        run_msg(32, 8, 1, 1, -1);

        check_eq("done_count", 32'(done_cnt), 32'(n_cmp > 0 ? done_cnt_expected() : 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Messages that finish normally: every run_msg without abort, counted independently.
    int ok_msgs = 0;
    always @(posedge CLK_IN) begin
        if (RC4_READ_PLAINTEXT_IN === 1'b1) ok_msgs <= ok_msgs + 1;
    end
    int abort_msgs = 0;
    always @(posedge CLK_IN) begin
        if (ABORT_IN === 1'b1 && BUSY_OUT === 1'b1) abort_msgs <= abort_msgs + 1;
    end

    function automatic int done_cnt_expected();
        return ok_msgs;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rc4_stream_feeder.md
# rc4_stream_feeder

Upstream sequencer for the `rc4` core. The host preloads the key into a 32-byte key store and pushes plaintext into a 16-entry FIFO. The block then drives the core's start, key-copy and plaintext interfaces cycle-exactly. It asserts `HOLD` toward the core whenever the plaintext FIFO runs dry mid-message.

## Interface
- `KEY_MAX`, 32: key store depth in bytes; fixed for the 256-bit key.
- `PT_DEPTH`, 16: plaintext FIFO depth; must be a power of 2.
- `PT_AW`, 4: log2(`PT_DEPTH`).

Ports (all `RC4_*` ports connect to the `rc4` core):
- `CLK_IN` in 1: single clock, rising edge.
- `RESET_N_IN` in 1: reset, asynchronous, active-low.
- `KEY_WE_IN` in 1: key store write strobe; ignored while `BUSY_OUT`=1.
- `KEY_ADDR_IN` in 5: key byte index.
- `KEY_DATA_IN` in 8: key byte.
- `KEY_LEN_IN` in 6: key length 1..32; 0 or >32 is treated as 32. Latched on accepted `GO_IN`.
- `PT_LEN_IN` in 16: message length in bytes; latched on accepted `GO_IN`.
- `GO_IN` in 1: start request. Accepted only in IDLE with `PT_LEN_IN`≠0.
- `ABORT_IN` in 1: abandon the current message.
- `PT_VALID_IN` in 1: plaintext push request.
- `PT_DATA_IN` in 8: plaintext byte.
- `PT_READY_OUT` out 1: FIFO not full (combinational).
- `BUSY_OUT` out 1: state ≠ IDLE.
- `DONE_OUT` out 1: one-cycle pulse when the last plaintext byte has been presented.
- `RC4_START_OUT` out 1: connects to core `START_IN`.
- `RC4_STOP_OUT` out 1: connects to core `STOP_IN`.
- `RC4_HOLD_OUT` out 1: connects to core `HOLD_IN`.
- `RC4_KEY_SIZE_OUT` out 8: connects to core `KEY_SIZE_IN`.
- `RC4_KEY_BYTE_OUT` out 8: connects to core `KEY_BYTE_IN`.
- `RC4_PLAIN_BYTE_OUT` out 8: connects to core `PLAIN_BYTE_IN`.
- `RC4_START_KEY_CPY_IN` in 1: from core `START_KEY_CPY_OUT`.
- `RC4_READ_PLAINTEXT_IN` in 1: from core `READ_PLAINTEXT_OUT`.

## Operation
- States: IDLE → START → WAIT_KCPY → KEY → WAIT_PT → PT → DONE → IDLE.
- **IDLE**
  - Accepted `GO_IN` latches the key length into `RC4_KEY_SIZE_OUT` and `PT_LEN_IN` into the remaining-byte counter `rem`.
  - Goes to START.
- **START**
  - `RC4_START_OUT`=1 for exactly one cycle.
  - Goes to WAIT_KCPY.
- **WAIT_KCPY**
  - On the edge sampling `RC4_START_KEY_CPY_IN`=1: `RC4_KEY_BYTE_OUT`←key[0], idx←1.
  - Goes to KEY.
- **KEY**
  - Each edge while idx<len: `RC4_KEY_BYTE_OUT`←key[idx], idx←idx+1.
  - On the edge where idx=len: `RC4_KEY_BYTE_OUT`←0, go to WAIT_PT.
  - Net effect: `len` consecutive bytes, then 0.
- **WAIT_PT**
  - On the edge sampling `RC4_READ_PLAINTEXT_IN`=1, perform the first PT step (below) and go to PT.
- **PT step**, one per edge:
  - If the FIFO is non-empty: pop, `RC4_PLAIN_BYTE_OUT`←head, `RC4_HOLD_OUT`←0, rem←rem−1.
  - If the FIFO is empty: `RC4_HOLD_OUT`←1, `RC4_PLAIN_BYTE_OUT` unchanged, rem unchanged.
  - In PT, on the edge after the step that brings rem to 0: `RC4_PLAIN_BYTE_OUT`←0, `RC4_HOLD_OUT`←0, go to DONE.
- **DONE**
  - `DONE_OUT`=1 for one cycle, then IDLE.
  - Surplus FIFO bytes are retained for the next message.
- **ABORT_IN** in any non-IDLE state:
  - Next edge: `RC4_STOP_OUT`=1 for one cycle, FIFO flushed, `RC4_HOLD_OUT`=0, byte outputs 0, go to IDLE.
  - No `DONE_OUT` pulse.
  - `ABORT_IN` in IDLE has no effect.
- **FIFO**
  - Push when `PT_VALID_IN`&`PT_READY_OUT`.
  - Push is allowed in any state, including IDLE (preload).
  - Empty and full are judged from the registered count. A push into an empty FIFO is poppable on the following edge, never on the same edge.
  - Simultaneous push and pop when non-empty and not full: count unchanged, order preserved.
- The key store is written only in IDLE. Key store contents are not cleared by reset.

## Timing
- **Reset values:** every output 0 except `PT_READY_OUT`=1. State IDLE, FIFO empty, idx=0, rem=0.
- **Start latency:** `GO_IN` sampled at edge N → `RC4_START_OUT` high during cycle N+1.
- **Key latency:** `RC4_START_KEY_CPY_IN` sampled at edge K → key[i] valid during cycle K+1+i, for i=0..len−1. Value 0 from K+1+len.
- **Plaintext latency:** `RC4_READ_PLAINTEXT_IN` sampled at edge P with no underrun → byte j valid during cycle P+1+j.
- **Underrun:** each empty-FIFO edge inserts one `HOLD` cycle and shifts subsequent bytes by one cycle.
- **Reset mid-operation:** all registers return to reset values immediately, asynchronously. No `STOP` pulse is generated.
- **Width rules:**
  - `rem` is 16-bit, with no wrap. PT_LEN=65535 is legal.
  - FIFO pointers are `PT_AW` bits wide and wrap modulo `PT_DEPTH`. The count is `PT_AW`+1 bits wide.

## Test plan
- **Reset:** assert `RESET_N_IN`=0 mid-cycle → all outputs 0 and `PT_READY_OUT`=1, without waiting for a clock edge.
- **Key stream:** load key ae6c3c41…b405, `KEY_LEN`=32, `GO`; core model pulses `START_KEY_CPY` 3 cycles later → `RC4_KEY_BYTE_OUT` = ae, 6c, 3c, … 05 on 32 consecutive cycles, then 00. `RC4_KEY_SIZE_OUT`=0x20.
- **Underrun:**
  - Stimulus: `PT_LEN`=4; preload 3a, e2; push 80, d0 five cycles after `READ_PLAINTEXT`.
  - Response: bytes 3a, e2 on consecutive cycles; `HOLD`=1 while the FIFO is empty; 80, d0 appear once pushed.
  - Then `DONE` pulses once.
- **FIFO full:** push 17 bytes in IDLE → `PT_READY_OUT`=0 after the 16th, 17th rejected; a later message of 16 bytes emits exactly the first 16.
- **Abort:** `ABORT_IN` during KEY at idx=10 → one `RC4_STOP_OUT` pulse, `BUSY_OUT`=0 next cycle, FIFO empty, no `DONE`. Key-store writes are accepted again.
- **End-to-end with `rc4` core:**
  - Stimulus: key ae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405; plaintext 3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595.
  - Required core ciphertext: 2280c9676c8f5c52aba8d42611f85e7ca961a2117d3cfc8236a6051bbfc5f179.
